// File: rtl/regfile_pkg.sv
// Shared register-file write-back definitions: widths, register count and the
// arbitration-state encoding used by the round-robin grant logic.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } arbState_t;

    // Register 0 is hardwired, so writes to it are accepted but dropped.
    function automatic logic isWritable(input logic [REG_ADDR_W-1:0] regAddr);
        return regAddr != '0;
    endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Two-requester write-back grant logic. With WB_ROUND_ROBIN_EN defined, ties
// alternate via a LAST_ALU/LAST_MEM FSM; otherwise Mem has fixed priority.
module wb_rr_arb
    import regfile_pkg::*;
(
`ifdef WB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic stall,
    input  logic aluValid,
    input  logic memValid,
    output logic aluReady,
    output logic memReady
);

`ifdef WB_ROUND_ROBIN_EN
    arbState_t state;

    always_comb begin
        aluReady = 1'b0;
        memReady = 1'b0;
        if (!stall) begin
            if (aluValid && memValid) begin
                if (state == LAST_MEM) aluReady = 1'b1;
                else                   memReady = 1'b1;
            end else begin
                aluReady = aluValid;
                memReady = memValid;
            end
        end
    end

    // Reset to LAST_MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LAST_MEM;
        end else if (aluValid && aluReady) begin
            state <= LAST_ALU;
        end else if (memValid && memReady) begin
            state <= LAST_MEM;
        end
    end
`else
    always_comb begin
        memReady = !stall && memValid;
        aluReady = !stall && aluValid && !memValid;
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one-cycle output register plus pending-writer
// scoreboard. Tie policy selected by WB_ROUND_ROBIN_EN (see wb_rr_arb).
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  AluValid,
    input  logic [REG_ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0]     AluData,
    output logic                  AluReady,
    input  logic                  MemValid,
    input  logic [REG_ADDR_W-1:0] MemReg,
    input  logic [DATA_W-1:0]     MemData,
    output logic                  MemReady,
    input  logic                  Reserve,
    input  logic [REG_ADDR_W-1:0] ReserveReg,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic [NUM_REGS-1:0]   Pending
);

    logic                  aluXfer;
    logic                  memXfer;
    logic                  anyXfer;
    logic [REG_ADDR_W-1:0] xferReg;
    logic [DATA_W-1:0]     xferData;
    logic [NUM_REGS-1:0]   pendingNext;

    wb_rr_arb uArb (
`ifdef WB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .stall    (Stall),
        .aluValid (AluValid),
        .memValid (MemValid),
        .aluReady (AluReady),
        .memReady (MemReady)
    );

    always_comb begin
        aluXfer  = AluValid && AluReady;
        memXfer  = MemValid && MemReady;
        anyXfer  = aluXfer || memXfer;
        xferReg  = aluXfer ? AluReg  : MemReg;
        xferData = aluXfer ? AluData : MemData;
    end

    // Clear before set so a same-edge reserve of the written register wins.
    always_comb begin
        pendingNext = Pending;
        if (anyXfer) begin
            pendingNext[xferReg] = 1'b0;
        end
        if (Reserve && isWritable(ReserveReg)) begin
            pendingNext[ReserveReg] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            Pending       <= '0;
        end else begin
            RegWrite <= anyXfer && isWritable(xferReg);
            if (anyXfer) begin
                WriteRegister <= xferReg;
                WriteData     <= xferData;
            end
            Pending <= pendingNext;
        end
    end

endmodule
